vc_switch_allocator: RTL and testbench

// - Shares one router output port between NUM_VC virtual-channel buffers, with round-robin arbitration on head flits.
// - Wormhole lock: the winning VC owns the port from head flit through tail flit.
// - Sits between the VC buffers and the switch/output link. One registered output stage drives the downstream valid/ready link.

---
 rtl/router_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/vc_switch_allocator.sv | 131 +++++++++++++
 tb/tb_vc_switch_allocator.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: allocator FSM state encoding and flit field widths.
// Used by the VC buffers, the switch allocator and the switch datapath.
package router_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int FLIT_DATA_W = 32;
  localparam int FLIT_CTRL_W = 2;  // head + tail flags carried beside the payload
  localparam int FLIT_W      = FLIT_DATA_W + FLIT_CTRL_W;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans requesters starting one past last_grant
// and returns the first hit as a one-hot grant plus its index.
module rr_arbiter #(
  parameter  int NUM_VC = 2,
  localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic [NUM_VC-1:0] req,
  input  logic [VC_W-1:0]   last_grant,
  output logic [NUM_VC-1:0] grant,
  output logic [VC_W-1:0]   grant_idx
);

  logic found;
  int   idx;

  // Offsets 1..NUM_VC visit every VC once, the previous winner last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 1; off <= NUM_VC; off++) begin
      idx = (int'(last_grant) + off) % NUM_VC;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = VC_W'(idx);
      end
    end
  end

endmodule

// File: rtl/vc_switch_allocator.sv
// Shares one output port between NUM_VC virtual channels: round-robin grant on head
// flits, wormhole lock until the tail, and a single registered valid/ready output stage.
module vc_switch_allocator
  import router_pkg::*;
#(
  parameter  int NUM_VC = 2,
  parameter  int DATA_W = FLIT_DATA_W,
  localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_VC-1:0]        vc_valid,
  input  logic [NUM_VC-1:0]        vc_head,
  input  logic [NUM_VC-1:0]        vc_tail,
  input  logic [NUM_VC*DATA_W-1:0] vc_data,
  output logic [NUM_VC-1:0]        vc_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_head,
  output logic                     out_tail,
  output logic [VC_W-1:0]          selected_vc,
  output logic                     busy,
  output logic                     err_orphan
);

  state_t              state_q, state_d;
  logic [VC_W-1:0]     last_grant_q;
  logic [VC_W-1:0]     selected_vc_q;
  logic [NUM_VC-1:0]   req;
  logic [NUM_VC-1:0]   arb_grant;
  logic [VC_W-1:0]     arb_idx;
  logic                grant_now;
  logic [NUM_VC-1:0]   ready_c;
  logic                xfer;
  logic                xfer_tail;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_head;
  logic                sel_tail;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic                out_head_q;
  logic                out_tail_q;
  logic                err_orphan_q;

  assign req = vc_valid & vc_head;

  rr_arbiter #(
    .NUM_VC (NUM_VC)
  ) u_arb (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  assign grant_now = (state_q == IDLE) && (|arb_grant);

  assign sel_data = vc_data[int'(selected_vc_q)*DATA_W +: DATA_W];
  assign sel_head = vc_head[selected_vc_q];
  assign sel_tail = vc_tail[selected_vc_q];

  // Ready depends only on lock state and the output slot, never on vc_valid,
  // so upstream can hold data without a combinational loop back through us.
  always_comb begin
    state_d   = state_q;
    ready_c   = '0;
    xfer      = 1'b0;
    xfer_tail = 1'b0;
    case (state_q)
      IDLE: begin
        if (|arb_grant) state_d = LOCKED;
      end
      LOCKED: begin
        ready_c[selected_vc_q] = !out_valid_q || out_ready;
        xfer      = vc_valid[selected_vc_q] && ready_c[selected_vc_q];
        xfer_tail = xfer && sel_tail;
        if (xfer_tail) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= VC_W'(NUM_VC - 1);
      selected_vc_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_now) selected_vc_q <= arb_idx;
      if (xfer_tail) last_grant_q  <= selected_vc_q;
    end
  end

  // Output slot: a load may coincide with a drain, giving one flit per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_head_q  <= 1'b0;
      out_tail_q  <= 1'b0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_head_q  <= sel_head;
      out_tail_q  <= sel_tail;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // A body/tail flit offered while nobody holds the lock means upstream lost sync.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_orphan_q <= 1'b0;
    end else begin
      err_orphan_q <= (state_q == IDLE) && (|(vc_valid & ~vc_head));
    end
  end

  assign vc_ready    = ready_c;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_head    = out_head_q;
  assign out_tail    = out_tail_q;
  assign selected_vc = selected_vc_q;
  assign busy        = (state_q == LOCKED);
  assign err_orphan  = err_orphan_q;

endmodule

// File: tb/tb_vc_switch_allocator.sv
// Self-checking bench for vc_switch_allocator: directed scenarios plus random traffic,
// all checked against a packet-level reference model of the allocation rules.
module tb_vc_switch_allocator;

  localparam int NUM_VC = 2;
  localparam int DATA_W = 32;
  localparam int VC_W   = 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              head;
    logic              tail;
  } flit_t;

  logic                     clk;
  logic                     reset;
  logic [NUM_VC-1:0]        vc_valid;
  logic [NUM_VC-1:0]        vc_head;
  logic [NUM_VC-1:0]        vc_tail;
  logic [NUM_VC*DATA_W-1:0] vc_data;
  logic [NUM_VC-1:0]        vc_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_head;
  logic                     out_tail;
  logic [VC_W-1:0]          selected_vc;
  logic                     busy;
  logic                     err_orphan;

  vc_switch_allocator #(
    .NUM_VC (NUM_VC),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vc_valid    (vc_valid),
    .vc_head     (vc_head),
    .vc_tail     (vc_tail),
    .vc_data     (vc_data),
    .vc_ready    (vc_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_head    (out_head),
    .out_tail    (out_tail),
    .selected_vc (selected_vc),
    .busy        (busy),
    .err_orphan  (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Upstream packet sources and stimulus knobs
  flit_t             srcq [NUM_VC][$];
  logic [NUM_VC-1:0] inj = '0;
  bit                rand_mode = 1'b0;
  logic              ready_val = 1'b1;

  // Reference model: lock owner, last winner, output slot contents
  bit    m_locked;
  int    m_owner;
  int    m_last;
  bit    m_ov;
  bit    m_orph;
  flit_t m_out;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic check_reset_vals();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_head", out_head, 0);
    checkOutput("rst_out_tail", out_tail, 0);
    checkOutput("rst_vc_ready", vc_ready, 0);
    checkOutput("rst_selected_vc", selected_vc, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err_orphan", err_orphan, 0);
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_last   = NUM_VC - 1;
    m_ov     = 1'b0;
    m_orph   = 1'b0;
    m_out    = '{data: '0, head: 1'b0, tail: 1'b0};
    for (int i = 0; i < NUM_VC; i++) srcq[i].delete();
    inj = '0;
  endtask

  task automatic clear_inputs();
    vc_valid  = '0;
    vc_head   = '0;
    vc_tail   = '0;
    vc_data   = '0;
    out_ready = 1'b0;
  endtask

  // Called with reset already high: checks reset values and releases at a negedge.
  task automatic finish_reset();
    clear_inputs();
    #1;
    check_reset_vals();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic add_packet(input int vc, input int len, input logic [DATA_W-1:0] base);
    flit_t f;
    for (int k = 0; k < len; k++) begin
      f.data = base + DATA_W'(k);
      f.head = (k == 0);
      f.tail = (k == len - 1);
      srcq[vc].push_back(f);
    end
  endtask

  // One clock: drive at negedge, check #1 later, then advance the model for the coming edge.
  task automatic applyStimulus();
    logic [NUM_VC-1:0]        vv, vh, vt, exp_ready, rq;
    logic [NUM_VC*DATA_W-1:0] vd;
    flit_t                    f;
    bit                       load, found;
    int                       idx;
    @(negedge clk);
    vv = '0; vh = '0; vt = '0; vd = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (inj[i]) begin
        vv[i] = 1'b1;
        vd[i*DATA_W +: DATA_W] = $urandom;
      end else if (srcq[i].size() > 0 && (!rand_mode || $urandom_range(3) != 0)) begin
        f = srcq[i][0];
        vv[i] = 1'b1;
        vh[i] = f.head;
        vt[i] = f.tail;
        vd[i*DATA_W +: DATA_W] = f.data;
      end
    end
    vc_valid  = vv;
    vc_head   = vh;
    vc_tail   = vt;
    vc_data   = vd;
    out_ready = rand_mode ? ($urandom_range(9) < 7) : ready_val;
    #1;
    checkOutput("busy", busy, m_locked);
    if (m_locked) checkOutput("selected_vc", selected_vc, m_owner);
    checkOutput("out_valid", out_valid, m_ov);
    if (m_ov) begin
      checkOutput("out_data", out_data, m_out.data);
      checkOutput("out_head", out_head, m_out.head);
      checkOutput("out_tail", out_tail, m_out.tail);
    end
    checkOutput("err_orphan", err_orphan, m_orph);
    exp_ready = '0;
    if (m_locked && (!m_ov || out_ready)) exp_ready[m_owner] = 1'b1;
    checkOutput("vc_ready", vc_ready, exp_ready);

    m_orph = !m_locked && (|(vv & ~vh));
    load = 1'b0;
    if (!m_locked) begin
      rq = vv & vh;
      found = 1'b0;
      for (int off = 1; off <= NUM_VC; off++) begin
        idx = (m_last + off) % NUM_VC;
        if (!found && rq[idx]) begin
          found   = 1'b1;
          m_owner = idx;
        end
      end
      if (found) m_locked = 1'b1;
    end else if (exp_ready[m_owner] && vv[m_owner]) begin
      f    = srcq[m_owner].pop_front();
      load = 1'b1;
      if (f.tail) begin
        m_locked = 1'b0;
        m_last   = m_owner;
      end
    end
    if (load) begin
      m_out = f;
      m_ov  = 1'b1;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
  endtask

  function automatic bit pending();
    bit p = m_locked || m_ov;
    for (int i = 0; i < NUM_VC; i++) if (srcq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain();
    int n = 0;
    while (pending() && n < 400) begin
      applyStimulus();
      n++;
    end
    if (n >= 400) checkOutput("drain_timeout", 1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1;
    clear_inputs();
    model_reset();
    #2;
    finish_reset();

    // Single requester: head/body/tail with out_ready held high
    add_packet(0, 3, 32'hA0);
    applyStimulus();
    checkOutput("lat_valid_c1", out_valid, 0);
    applyStimulus();
    checkOutput("lat_valid_c2", out_valid, 0);
    checkOutput("lat_busy_c2", busy, 1);
    applyStimulus();
    checkOutput("lat_valid_c3", out_valid, 1);
    checkOutput("lat_data_c3", out_data, 32'hA0);
    applyStimulus();
    checkOutput("single_body", out_data, 32'hA1);
    applyStimulus();
    checkOutput("single_tail_data", out_data, 32'hA2);
    checkOutput("single_tail_flag", out_tail, 1);
    checkOutput("single_busy_drop", busy, 0);
    drain();

    // Contention at reset release, then round-robin after a VC0-only packet
    @(negedge clk);
    reset = 1'b1;
    finish_reset();
    add_packet(0, 3, 32'h100);
    add_packet(1, 2, 32'h200);
    applyStimulus();
    applyStimulus();
    checkOutput("contend_vc0_first", selected_vc, 0);
    drain();
    add_packet(0, 2, 32'h300);
    drain();
    add_packet(0, 2, 32'h400);
    add_packet(1, 2, 32'h500);
    applyStimulus();
    applyStimulus();
    checkOutput("rr_vc1_first", selected_vc, 1);
    drain();

    // Interleave guard: VC1 head arrives while VC0 holds the lock
    add_packet(0, 4, 32'hD0);
    applyStimulus();
    applyStimulus();
    add_packet(1, 3, 32'hE0);
    n = 0;
    while (srcq[0].size() > 0 && n < 50) begin
      applyStimulus();
      checkOutput("guard_ready1", vc_ready[1], 0);
      n++;
    end
    drain();

    // Back-pressure mid-packet for 5 cycles
    add_packet(0, 8, 32'hC0);
    n = 0;
    while (srcq[0].size() > 5 && n < 50) begin
      applyStimulus();
      n++;
    end
    ready_val = 1'b0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus();
      checkOutput("bp_ready", vc_ready, 0);
      checkOutput("bp_hold", out_data, m_out.data);
    end
    ready_val = 1'b1;
    drain();

    // Orphan body flit on VC1 while idle
    inj[1] = 1'b1;
    applyStimulus();
    inj = '0;
    applyStimulus();
    checkOutput("orphan_pulse", err_orphan, 1);
    checkOutput("orphan_ready", vc_ready[1], 0);
    checkOutput("orphan_nogrant", busy, 0);
    applyStimulus();
    checkOutput("orphan_clear", err_orphan, 0);
    drain();

    // Reset while body flit 2 is presented; next head must go to VC0 first
    add_packet(1, 5, 32'hB0);
    n = 0;
    while (srcq[1].size() > 2 && n < 50) begin
      applyStimulus();
      n++;
    end
    reset = 1'b1;
    finish_reset();
    add_packet(1, 2, 32'hF0);
    add_packet(0, 2, 32'hF8);
    applyStimulus();
    applyStimulus();
    checkOutput("post_reset_vc0", selected_vc, 0);
    drain();

    // Random traffic with random gaps and back-pressure
    rand_mode = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NUM_VC; i++)
        if (srcq[i].size() == 0 && $urandom_range(3) == 0)
          add_packet(i, $urandom_range(4, 1), $urandom);
      applyStimulus();
    end
    drain();
    rand_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
